// File: rtl/alu_serial_p.sv
// alu_serial_p: serially loaded ALU with stored opcode, sliced result readback,
// full status flags and an iterative one-bit-per-cycle shifter.
module alu_serial_p #(
   parameter int WIDTH = 32,
   parameter int IN_W  = 8,
   parameter int OUT_W = 16,
   localparam int BEATS  = WIDTH / IN_W,
   localparam int SLICES = WIDTH / OUT_W,
   localparam int SW     = $clog2(WIDTH),
   localparam int SELW   = (SLICES > 1) ? $clog2(SLICES) : 1,
   localparam int LDW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  A,
   input  logic [IN_W-1:0]  B,
   input  logic             ld,
   input  logic             opLd,
   input  logic             exe,
   input  logic [SELW-1:0]  sel,
   output logic [OUT_W-1:0] res,
   output logic             carryflag,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic             err,
   output logic             busy,
   output logic             done,
   output logic [LDW-1:0]   ld_cnt
);

   typedef enum logic [3:0] {
      K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_NOT, K_SLA, K_SRA, K_SRL, K_BAD
   } kind_t;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [5:0]       opcode;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] work;
   logic [SW-1:0]    cnt;

   kind_t            kind;
   logic [5:0]       base_op;
   logic [SW-1:0]    amt;
   logic             is_shift;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] ev_res;
   logic             ev_c;
   logic             ev_v;
   logic             ev_err;
   logic [WIDTH-1:0] shifted;
   logic             shout;

   // Fold the immediate opcode aliases (9..17) onto their base operations.
   always_comb begin
      base_op = opcode - 6'd9;
      kind    = K_BAD;
      if (opcode <= 6'd8)
         kind = kind_t'(opcode[3:0]);
      else if (opcode <= 6'd17)
         kind = kind_t'(base_op[3:0]);
   end

   // Single-cycle result and flags for non-shift ops; a shift by zero passes A through.
   always_comb begin
      amt      = op_b[SW-1:0];
      is_shift = (kind == K_SLA) || (kind == K_SRA) || (kind == K_SRL);
      sum      = {1'b0, op_a} + {1'b0, op_b};
      diff     = {1'b0, op_a} - {1'b0, op_b};
      ev_res   = '0;
      ev_c     = 1'b0;
      ev_v     = 1'b0;
      ev_err   = 1'b0;
      case (kind)
         K_ADD: begin
            ev_res = sum[WIDTH-1:0];
            ev_c   = sum[WIDTH];
            ev_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
         end
         K_SUB: begin
            ev_res = diff[WIDTH-1:0];
            ev_c   = diff[WIDTH];
            ev_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
         end
         K_AND:                ev_res = op_a & op_b;
         K_OR:                 ev_res = op_a | op_b;
         K_XOR:                ev_res = op_a ^ op_b;
         K_NOT:                ev_res = ~op_a;
         K_SLA, K_SRA, K_SRL:  ev_res = op_a;
         default:              ev_err = 1'b1;
      endcase
   end

   // One-bit shift step of the working register, plus the bit that falls out.
   always_comb begin
      shifted = work;
      shout   = 1'b0;
      case (kind)
         K_SLA: begin
            shifted = {work[WIDTH-2:0], 1'b0};
            shout   = work[WIDTH-1];
         end
         K_SRA: begin
            shifted = {work[WIDTH-1], work[WIDTH-1:1]};
            shout   = work[0];
         end
         K_SRL: begin
            shifted = {1'b0, work[WIDTH-1:1]};
            shout   = work[0];
         end
         default: begin
            shifted = work;
            shout   = 1'b0;
         end
      endcase
   end

   // Control FSM: beat loading, opcode latch, execution and iterative shifting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         opcode    <= '0;
         result    <= '0;
         work      <= '0;
         cnt       <= '0;
         carryflag <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ld_cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (exe) begin
                  ld_cnt <= '0;
                  if (is_shift && (amt != '0)) begin
                     cnt   <= amt;
                     work  <= op_a;
                     busy  <= 1'b1;
                     state <= SHIFT;
                  end else begin
                     result    <= ev_res;
                     carryflag <= ev_c;
                     ovf       <= ev_v;
                     err       <= ev_err;
                     zero      <= !ev_err && (ev_res == '0);
                     neg       <= !ev_err && ev_res[WIDTH-1];
                     done      <= 1'b1;
                  end
               end else if (ld) begin
                  ld_cnt <= (ld_cnt == LDW'(BEATS - 1)) ? '0 : ld_cnt + 1'b1;
               end
               if (ld) begin
                  op_a[ld_cnt*IN_W +: IN_W] <= A;
                  op_b[ld_cnt*IN_W +: IN_W] <= B;
               end
               if (opLd)
                  opcode <= B[5:0];
            end
            SHIFT: begin
               work <= shifted;
               cnt  <= cnt - 1'b1;
               if (cnt == SW'(1)) begin
                  result    <= shifted;
                  carryflag <= shout;
                  zero      <= (shifted == '0);
                  neg       <= shifted[WIDTH-1];
                  ovf       <= 1'b0;
                  err       <= 1'b0;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign res = result[sel*OUT_W +: OUT_W];

endmodule

// File: tb/tb_alu_serial_p.sv
// tb_alu_serial_p: directed stimulus with a cycle-level reference model and literal checks.
module tb_alu_serial_p;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  A = '0;
   logic [7:0]  B = '0;
   logic        ld = 1'b0;
   logic        opLd = 1'b0;
   logic        exe = 1'b0;
   logic [0:0]  sel = '0;
   logic [15:0] res;
   logic        carryflag, zero, neg, ovf, err, busy, done;
   logic [1:0]  ld_cnt;

   int testsRun = 0;
   int testsFailed = 0;

   // Reference model state
   logic [31:0] mA, mB, mRes;
   logic [5:0]  mOp;
   logic        mC, mZ, mN, mV, mE, mBusy, mDone;
   logic [1:0]  mLdCnt;
   int          mRem;
   logic [31:0] pRes;
   logic        pC, pZ, pN, pV, pE;

   alu_serial_p dut (
      .clk(clk), .rst(rst), .A(A), .B(B), .ld(ld), .opLd(opLd), .exe(exe),
      .sel(sel), .res(res), .carryflag(carryflag), .zero(zero), .neg(neg),
      .ovf(ovf), .err(err), .busy(busy), .done(done), .ld_cnt(ld_cnt)
   );

   always #5 clk = ~clk;

   // Compares one observed value with the expected one and keeps the tallies.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      testsRun++;
      if (act !== expv) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Direct arithmetic definition of every operation from its opcode.
   function automatic void calc(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic z,
                                output logic n, output logic v, output logic e);
      int     k;
      int     sh;
      longint s;
      k  = (op <= 8) ? int'(op) : ((op <= 17) ? int'(op) - 9 : -1);
      sh = int'(b[4:0]);
      r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
      case (k)
         0: begin
            r = a + b;
            c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
            s = longint'($signed(a)) + longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         1: begin
            r = a - b;
            c = a < b;
            s = longint'($signed(a)) - longint'($signed(b));
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = ~a;
         6: begin r = a << sh; c = (sh != 0) ? a[32 - sh] : 1'b0; end
         7: begin r = $signed(a) >>> sh; c = (sh != 0) ? a[sh - 1] : 1'b0; end
         8: begin r = a >> sh; c = (sh != 0) ? a[sh - 1] : 1'b0; end
         default: e = 1'b1;
      endcase
      z = !e && (r == 0);
      n = !e && r[31];
   endfunction

   // Cycle-level model: shifts finish n edges after exe; everything is frozen meanwhile.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mA = '0; mB = '0; mOp = '0; mRes = '0;
         {mC, mZ, mN, mV, mE, mBusy, mDone} = '0;
         mLdCnt = '0; mRem = 0;
      end else begin
         mDone = 1'b0;
         if (mRem > 0) begin
            mRem--;
            if (mRem == 0) begin
               mRes = pRes; mC = pC; mZ = pZ; mN = pN; mV = pV; mE = pE;
               mDone = 1'b1; mBusy = 1'b0;
            end
         end else begin
            if (exe) begin
               calc(mOp, mA, mB, pRes, pC, pZ, pN, pV, pE);
               if (((mOp % 9) >= 6) && (mOp <= 17) && (mB[4:0] != 0) && !(mOp >= 9 && mOp <= 14)) begin
                  mRem = int'(mB[4:0]);
                  mBusy = 1'b1;
               end else begin
                  mRes = pRes; mC = pC; mZ = pZ; mN = pN; mV = pV; mE = pE;
                  mDone = 1'b1;
               end
            end
            if (ld) begin
               mA[mLdCnt*8 +: 8] = A;
               mB[mLdCnt*8 +: 8] = B;
            end
            if (exe) mLdCnt = '0;
            else if (ld) mLdCnt = mLdCnt + 2'd1;
            if (opLd) mOp = B[5:0];
         end
      end
   end

   // Every cycle out of reset, all outputs must match the model.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("res", {16'd0, res}, {16'd0, mRes[sel*16 +: 16]});
         checkOutput("flags", {27'd0, carryflag, zero, neg, ovf, err}, {27'd0, mC, mZ, mN, mV, mE});
         checkOutput("busy_done", {30'd0, busy, done}, {30'd0, mBusy, mDone});
         checkOutput("ld_cnt", {30'd0, ld_cnt}, {30'd0, mLdCnt});
      end
   end

   // Drives one cycle of control inputs, then releases the strobes.
   task automatic applyStimulus(input logic l, input logic o, input logic e,
                                input logic [7:0] a, input logic [7:0] b);
      ld = l; opLd = o; exe = e; A = a; B = b;
      @(posedge clk);
      #2;
      ld = 1'b0; opLd = 1'b0; exe = 1'b0;
   endtask

   task automatic loadAB(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, a[i*8 +: 8], b[i*8 +: 8]);
   endtask

   task automatic checkRes(input string name, input logic [31:0] expv);
      sel = 1'b0; #1;
      checkOutput({name, "_lo"}, {16'd0, res}, {16'd0, expv[15:0]});
      sel = 1'b1; #1;
      checkOutput({name, "_hi"}, {16'd0, res}, {16'd0, expv[31:16]});
      sel = 1'b0;
   endtask

   task automatic checkFlags(input string name, input logic [4:0] expv);
      checkOutput(name, {27'd0, carryflag, zero, neg, ovf, err}, {27'd0, expv});
   endtask

   task automatic waitDone(output int cycles);
      cycles = 0;
      while (busy && cycles < 200) begin
         @(posedge clk);
         #2;
         cycles++;
      end
      if (busy) checkOutput("timeout", 32'd1, 32'd0);
   endtask

   // Model self-checks against hand-computed values.
   task automatic pinModel();
      logic [31:0] r;
      logic c, z, n, v, e;
      calc(6'd0, 32'h89ABCDEF, 32'h12345678, r, c, z, n, v, e);
      checkOutput("model_add", r, 32'h9BE02467);
      calc(6'd1, 32'h80000000, 32'h1, r, c, z, n, v, e);
      checkOutput("model_sub_ovf", {31'd0, v}, 32'd1);
      calc(6'd7, 32'h80000000, 32'd4, r, c, z, n, v, e);
      checkOutput("model_sra", r, 32'hF8000000);
   endtask

   initial begin
      int cyc;
      pinModel();
      #12;
      checkRes("reset_res", 32'h0);
      checkFlags("reset_flags", 5'b00000);
      checkOutput("reset_busy_done_ldcnt", {28'd0, busy, done, ld_cnt}, 32'd0);
      #5 rst = 1'b0;

      loadAB(32'h89ABCDEF, 32'h12345678);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      checkOutput("add_done", {31'd0, done}, 32'd1);
      checkRes("add_res", 32'h9BE02467);
      checkFlags("add_flags", 5'b00100);

      loadAB(32'hFFFFFFFF, 32'h00000001);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      checkRes("add_wrap", 32'h0);
      checkFlags("add_wrap_flags", 5'b11000);

      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h01);
      loadAB(32'h80000000, 32'h00000001);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      checkRes("sub_res", 32'h7FFFFFFF);
      checkFlags("sub_flags", 5'b00010);

      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h07);
      loadAB(32'h80000000, 32'h00000004);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      checkOutput("sra_busy", {31'd0, busy}, 32'd1);
      waitDone(cyc);
      checkOutput("sra_latency", cyc, 32'd4);
      checkOutput("sra_done", {31'd0, done}, 32'd1);
      checkRes("sra_res", 32'hF8000000);
      checkFlags("sra_flags", 5'b00100);

      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h08);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      waitDone(cyc);
      checkRes("srl_res", 32'h08000000);

      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h06);
      loadAB(32'h80000001, 32'h00000001);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      waitDone(cyc);
      checkOutput("sla_latency", cyc, 32'd1);
      checkRes("sla_res", 32'h00000002);
      checkFlags("sla_flags", 5'b10000);

      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h07);
      loadAB(32'h80000000, 32'd31);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 1'b1, 1'b1, 8'h55, 8'h02);
      checkOutput("frozen_ldcnt", {30'd0, ld_cnt}, 32'd0);
      checkOutput("frozen_busy", {31'd0, busy}, 32'd1);
      waitDone(cyc);
      checkOutput("sra31_latency", cyc, 32'd28);
      checkRes("sra31_res", 32'hFFFFFFFF);
      checkFlags("sra31_flags", 5'b00100);

      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2;
      end
      rst = 1'b1;
      #1;
      checkOutput("rst_busy_done_ldcnt", {28'd0, busy, done, ld_cnt}, 32'd0);
      checkRes("rst_res", 32'h0);
      @(posedge clk);
      #2 rst = 1'b0;

      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h3F);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      checkRes("err_res", 32'h0);
      checkFlags("err_flags", 5'b00001);

      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h06);
      loadAB(32'h12345678, 32'h00000000);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      checkOutput("sla0_busy_done", {30'd0, busy, done}, 32'd1);
      checkRes("sla0_res", 32'h12345678);

      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      loadAB(32'h00000005, 32'h00000003);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'hAA, 8'hBB);
      checkRes("ldexe_old_ops", 32'h00000008);
      checkOutput("ldexe_ldcnt", {30'd0, ld_cnt}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      checkRes("ldexe_new_beat", 32'h00000165);

      for (int i = 1; i <= 5; i++)
         applyStimulus(1'b1, 1'b0, 1'b0, 8'(i), 8'h00);
      checkOutput("wrap_ldcnt", {30'd0, ld_cnt}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
      checkRes("wrap_res", 32'h04030205);

      @(posedge clk);
      #2;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
